// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall sequencer states and the opcode
// constants that hazard detection and decode also use.
package pipe_pkg;

  // Stall sequencer states; the encodings match the legacy RTL.
  typedef enum logic [1:0] {
    RUN = 2'd0,
    HAZ = 2'd1,
    MUL = 2'd2
  } stall_state_e;

  // Primary opcode field values.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_MUL   = 6'b011100;

  // Front-end control bundle produced by the stall sequencer.
  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic hold_id_ex;
    logic bubble_id_ex;
    logic flush_if_id;
    logic mul_busy;
  } stall_ctrl_t;

  localparam stall_ctrl_t CTRL_IDLE = '0;

  // True when 'value' can be held in an unsigned counter of 'width' bits.
  function automatic logic fits_cnt(input int unsigned value,
                                    input int unsigned width);
    return (width >= 32) || (value < (32'd1 << width));
  endfunction

endpackage : pipe_pkg

// File: rtl/stall_counter.sv
// Episode-length counter shared by the hazard and multiply stall paths.
// Synchronous active-low reset; clear wins over increment.
module stall_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  // Count register: cleared by reset or clr, otherwise steps on inc.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Terminal compare against the limit selected by the current episode.
  always_comb begin
    at_term = (count == term);
  end

endmodule : stall_counter

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Turns the hazard
// level, taken-branch pulse and multiply start into prioritised Mealy
// enables for PC, IF/ID and ID/EX, and owns the multiply occupancy counter
// and the hazard-stall watchdog.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT   = 4,
  parameter int unsigned MAX_STALL = 7,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Haz_Req,
  input  logic             Br_Taken,
  input  logic             Mul_Start,
  output logic             Stall_PC,
  output logic             Stall_IF_ID,
  output logic             Hold_ID_EX,
  output logic             Bubble_ID_EX,
  output logic             Flush_IF_ID,
  output logic             Mul_Busy,
  output logic [CNT_W-1:0] Stall_Count,
  output logic             Watchdog
);

  // Both episode limits must be representable so the counter never wraps.
  if (MUL_LAT < 2) begin : g_bad_mul_lat
    $error("pipe_stall_ctrl: MUL_LAT must be at least 2");
  end
  if (MAX_STALL < 1) begin : g_bad_max_stall
    $error("pipe_stall_ctrl: MAX_STALL must be at least 1");
  end
  if (!fits_cnt(MUL_LAT - 1, CNT_W) || !fits_cnt(MAX_STALL, CNT_W)) begin : g_bad_cnt_w
    $error("pipe_stall_ctrl: CNT_W too narrow for MUL_LAT-1 / MAX_STALL");
  end

  localparam logic [CNT_W-1:0] MUL_TERM = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] HAZ_TERM = CNT_W'(MAX_STALL);

  stall_state_e     state_q;
  stall_state_e     state_d;
  stall_ctrl_t      ctrl;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_term;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_hit;
  logic             wd_set;
  logic             wd_q;

  stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk     (Clock),
    .rst_n   (Reset),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .term    (cnt_term),
    .count   (cnt_q),
    .at_term (cnt_hit)
  );

  // Next-state, counter control and Mealy output decode.
  // The counter sits at 0 in RUN, so an increment on episode entry loads 1.
  always_comb begin
    state_d  = state_q;
    ctrl     = CTRL_IDLE;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    cnt_term = HAZ_TERM;
    wd_set   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (Br_Taken) begin
          ctrl.flush_if_id  = 1'b1;
          ctrl.bubble_id_ex = 1'b1;
          cnt_clr           = 1'b1;
        end else if (Mul_Start) begin
          ctrl.stall_pc    = 1'b1;
          ctrl.stall_if_id = 1'b1;
          ctrl.hold_id_ex  = 1'b1;
          ctrl.mul_busy    = 1'b1;
          cnt_inc          = 1'b1;
          state_d          = MUL;
        end else if (Haz_Req) begin
          ctrl.stall_pc     = 1'b1;
          ctrl.stall_if_id  = 1'b1;
          ctrl.bubble_id_ex = 1'b1;
          cnt_inc           = 1'b1;
          state_d           = HAZ;
        end
      end
      HAZ: begin
        if (Br_Taken) begin
          ctrl.flush_if_id  = 1'b1;
          ctrl.bubble_id_ex = 1'b1;
          cnt_clr           = 1'b1;
          state_d           = RUN;
        end else if (Haz_Req && !cnt_hit) begin
          ctrl.stall_pc     = 1'b1;
          ctrl.stall_if_id  = 1'b1;
          ctrl.bubble_id_ex = 1'b1;
          cnt_inc           = 1'b1;
        end else begin
          // Hazard dropped, or the watchdog forces a release.
          wd_set  = Haz_Req;
          cnt_clr = 1'b1;
          state_d = RUN;
        end
      end
      MUL: begin
        cnt_term = MUL_TERM;
        if (!cnt_hit) begin
          ctrl.stall_pc    = 1'b1;
          ctrl.stall_if_id = 1'b1;
          ctrl.hold_id_ex  = 1'b1;
          ctrl.mul_busy    = 1'b1;
          cnt_inc          = 1'b1;
        end else begin
          cnt_clr = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = RUN;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wd_q <= 1'b0;
    end else if (wd_set) begin
      wd_q <= 1'b1;
    end
  end

  // Output drive: everything is forced low while reset is held.
  always_comb begin
    Stall_PC     = Reset & ctrl.stall_pc;
    Stall_IF_ID  = Reset & ctrl.stall_if_id;
    Hold_ID_EX   = Reset & ctrl.hold_id_ex;
    Bubble_ID_EX = Reset & ctrl.bubble_id_ex;
    Flush_IF_ID  = Reset & ctrl.flush_if_id;
    Mul_Busy     = Reset & ctrl.mul_busy;
    Stall_Count  = Reset ? cnt_q : '0;
    Watchdog     = Reset & wd_q;
  end

endmodule : pipe_stall_ctrl

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with MUL_LAT=4, MAX_STALL=7, CNT_W=3.
// Each step drives inputs just after a rising edge and checks the full
// output vector {Stall_PC, Stall_IF_ID, Hold_ID_EX, Bubble_ID_EX,
// Flush_IF_ID, Mul_Busy, Stall_Count[2:0], Watchdog} on the falling edge.
module tb_pipe_stall_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Haz_Req;
  logic       Br_Taken;
  logic       Mul_Start;
  logic       Stall_PC;
  logic       Stall_IF_ID;
  logic       Hold_ID_EX;
  logic       Bubble_ID_EX;
  logic       Flush_IF_ID;
  logic       Mul_Busy;
  logic [2:0] Stall_Count;
  logic       Watchdog;
  logic [9:0] obs;

  int checks = 0;
  int errors = 0;

  pipe_stall_ctrl #(
    .MUL_LAT   (4),
    .MAX_STALL (7),
    .CNT_W     (3)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Haz_Req      (Haz_Req),
    .Br_Taken     (Br_Taken),
    .Mul_Start    (Mul_Start),
    .Stall_PC     (Stall_PC),
    .Stall_IF_ID  (Stall_IF_ID),
    .Hold_ID_EX   (Hold_ID_EX),
    .Bubble_ID_EX (Bubble_ID_EX),
    .Flush_IF_ID  (Flush_IF_ID),
    .Mul_Busy     (Mul_Busy),
    .Stall_Count  (Stall_Count),
    .Watchdog     (Watchdog)
  );

  always #5 Clock = ~Clock;

  assign obs = {Stall_PC, Stall_IF_ID, Hold_ID_EX, Bubble_ID_EX,
                Flush_IF_ID, Mul_Busy, Stall_Count, Watchdog};

  // Expected vector: stall drives both Stall_PC and Stall_IF_ID.
  function automatic logic [9:0] e(input logic sp, input logic hold,
                                   input logic bub, input logic fl,
                                   input logic busy, input logic [2:0] cnt,
                                   input logic wd);
    return {sp, sp, hold, bub, fl, busy, cnt, wd};
  endfunction

  // One cycle: drive inputs, check Mealy outputs mid-cycle, advance.
  task automatic step(input logic r, input logic h, input logic b,
                      input logic m, input logic [9:0] exp,
                      input string tag);
    Reset     = r;
    Haz_Req   = h;
    Br_Taken  = b;
    Mul_Start = m;
    @(negedge Clock);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    // Reset held with a hazard pending: all outputs low.
    step(0, 1, 0, 0, e(0,0,0,0,0,3'd0,0), "rst_hold0");
    step(0, 1, 0, 0, e(0,0,0,0,0,3'd0,0), "rst_hold1");
    step(1, 0, 0, 0, e(0,0,0,0,0,3'd0,0), "rst_release");

    // Three-cycle hazard from RUN.
    step(1, 1, 0, 0, e(1,0,1,0,0,3'd0,0), "haz3_c0");
    step(1, 1, 0, 0, e(1,0,1,0,0,3'd1,0), "haz3_c1");
    step(1, 1, 0, 0, e(1,0,1,0,0,3'd2,0), "haz3_c2");
    step(1, 0, 0, 0, e(0,0,0,0,0,3'd3,0), "haz3_drop");
    step(1, 0, 0, 0, e(0,0,0,0,0,3'd0,0), "haz3_run");

    // Multiply, with a taken branch injected in its third cycle.
    step(1, 0, 0, 1, e(1,1,0,0,1,3'd0,0), "mul_c0");
    step(1, 0, 0, 0, e(1,1,0,0,1,3'd1,0), "mul_c1");
    step(1, 0, 1, 0, e(1,1,0,0,1,3'd2,0), "mul_c2_br");
    step(1, 0, 0, 0, e(0,0,0,0,0,3'd3,0), "mul_last");
    step(1, 0, 0, 0, e(0,0,0,0,0,3'd0,0), "mul_run");

    // Branch beats hazard in RUN; next state is RUN (count re-enters at 0).
    step(1, 1, 1, 0, e(0,0,1,1,0,3'd0,0), "br_haz_run");
    step(1, 1, 0, 0, e(1,0,1,0,0,3'd0,0), "br_then_haz");
    // Branch beats hazard in HAZ; multiply start ignored in HAZ.
    step(1, 1, 0, 1, e(1,0,1,0,0,3'd1,0), "haz_mul_ignored");
    step(1, 1, 1, 0, e(0,0,1,1,0,3'd2,0), "br_in_haz");
    step(1, 0, 0, 0, e(0,0,0,0,0,3'd0,0), "br_in_haz_run");

    // Multiply beats hazard in RUN; hazard ignored through the episode.
    step(1, 1, 0, 1, e(1,1,0,0,1,3'd0,0), "mul_haz_c0");
    step(1, 1, 0, 0, e(1,1,0,0,1,3'd1,0), "mul_haz_c1");
    step(1, 1, 0, 0, e(1,1,0,0,1,3'd2,0), "mul_haz_c2");
    step(1, 1, 0, 0, e(0,0,0,0,0,3'd3,0), "mul_haz_last");
    step(1, 1, 0, 0, e(1,0,1,0,0,3'd0,0), "mul_haz_after");
    step(1, 0, 0, 0, e(0,0,0,0,0,3'd1,0), "mul_haz_drop");

    // Hazard held 10 cycles: 7 stalled cycles, forced release, new episode.
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 0, 0, e(1,0,1,0,0,3'(i),0), $sformatf("wd_stall%0d", i));
    end
    step(1, 1, 0, 0, e(0,0,0,0,0,3'd7,0), "wd_release");
    step(1, 1, 0, 0, e(1,0,1,0,0,3'd0,1), "wd_restart0");
    step(1, 1, 0, 0, e(1,0,1,0,0,3'd1,1), "wd_restart1");
    step(1, 0, 0, 0, e(0,0,0,0,0,3'd2,1), "wd_drop");
    step(1, 0, 0, 0, e(0,0,0,0,0,3'd0,1), "wd_sticky");

    // Reset in the second cycle of a multiply.
    step(1, 0, 0, 1, e(1,1,0,0,1,3'd0,1), "rstmul_c0");
    step(0, 0, 0, 0, e(0,0,0,0,0,3'd0,0), "rstmul_low");
    step(1, 0, 0, 0, e(0,0,0,0,0,3'd0,0), "rstmul_run");
    step(1, 1, 0, 0, e(1,0,1,0,0,3'd0,0), "rstmul_haz");
    step(1, 0, 0, 0, e(0,0,0,0,0,3'd1,0), "rstmul_haz_drop");

    // Reset in the middle of a hazard episode.
    step(1, 1, 0, 0, e(1,0,1,0,0,3'd0,0), "rsthaz_c0");
    step(1, 1, 0, 0, e(1,0,1,0,0,3'd1,0), "rsthaz_c1");
    step(0, 1, 0, 0, e(0,0,0,0,0,3'd0,0), "rsthaz_low");
    step(1, 1, 0, 0, e(1,0,1,0,0,3'd0,0), "rsthaz_restart");
    step(1, 0, 0, 0, e(0,0,0,0,0,3'd1,0), "rsthaz_drop");
    step(1, 0, 0, 0, e(0,0,0,0,0,3'd0,0), "final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stall_ctrl
